// File: rtl/alu_disp_sequencer.sv
// Captures an ALU operand/result snapshot and cycles it through four hex frames
// for the seg7x16 driver, advancing on a timed tick or a debounced push-button.
module alu_disp_sequencer #(
    parameter int TICK_DIV        = 33554432,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    input  logic        i_zero,
    input  logic        i_auto,
    input  logic        i_step,
    output logic [63:0] o_data,
    output logic        o_disp_mode,
    output logic [1:0]  o_frame,
    output logic [3:0]  o_led
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        F_A     = 2'd0,
        F_B     = 2'd1,
        F_C     = 2'd2,
        F_FLAGS = 2'd3
    } frame_t;

    frame_t          state;
    frame_t          state_next;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic            step_s1;
    logic            step_s2;
    logic            db_level;
    logic            db_prev;
    logic [DW-1:0]   db_cnt;
    logic            step_pulse;
    logic            advance;
    logic            init_done;
    logic            load_snap;
    logic [31:0]     sa;
    logic [31:0]     sb;
    logic [31:0]     sc;
    logic            sz;
    logic [31:0]     frame_word;

    // Held at zero outside auto mode, so every auto entry restarts a full period
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_cnt <= '0;
        end else if (!i_auto || tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick = i_auto && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            step_s1  <= 1'b0;
            step_s2  <= 1'b0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            step_s1 <= i_step;
            step_s2 <= step_s1;
            db_prev <= db_level;
            if (step_s2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= step_s2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    assign step_pulse = db_level & ~db_prev;
    assign advance    = i_auto ? tick : step_pulse;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= F_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (advance) begin
            case (state)
                F_A:     state_next = F_B;
                F_B:     state_next = F_C;
                F_C:     state_next = F_FLAGS;
                F_FLAGS: state_next = F_A;
                default: state_next = F_A;
            endcase
        end
    end

    // Reload only at the wrap so a full pass always shows one coherent operation
    assign load_snap = !init_done || (advance && state == F_FLAGS);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            init_done <= 1'b0;
            sa        <= '0;
            sb        <= '0;
            sc        <= '0;
            sz        <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (load_snap) begin
                sa <= i_a;
                sb <= i_b;
                sc <= i_c;
                sz <= i_zero;
            end
        end
    end

    always_comb begin
        frame_word = '0;
        case (state)
            F_A:     frame_word = sa;
            F_B:     frame_word = sb;
            F_C:     frame_word = sc;
            F_FLAGS: frame_word = {31'b0, sz};
            default: frame_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_data  <= '0;
            o_frame <= 2'd0;
            o_led   <= 4'b0001;
        end else begin
            o_data  <= {32'b0, frame_word};
            o_frame <= state;
            o_led   <= 4'b0001 << state;
        end
    end

    assign o_disp_mode = 1'b0;

endmodule

// File: tb/tb_alu_disp_sequencer.sv
// Randomized and directed bench for alu_disp_sequencer, checked against a
// cycle-level behavioural model of the display sequencing rules.
module tb_alu_disp_sequencer;

    localparam int TICK_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 8;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] i_a  = '0;
    logic [31:0] i_b  = '0;
    logic [31:0] i_c  = '0;
    logic        i_zero = 1'b0;
    logic        i_auto = 1'b0;
    logic        i_step = 1'b0;
    logic [63:0] o_data;
    logic        o_disp_mode;
    logic [1:0]  o_frame;
    logic [3:0]  o_led;

    int checks = 0;
    int errors = 0;

    alu_disp_sequencer #(
        .TICK_DIV(TICK_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .i_a(i_a),
        .i_b(i_b),
        .i_c(i_c),
        .i_zero(i_zero),
        .i_auto(i_auto),
        .i_step(i_step),
        .o_data(o_data),
        .o_disp_mode(o_disp_mode),
        .o_frame(o_frame),
        .o_led(o_led)
    );

    always #5 clk = ~clk;

    // Reference model state: snapshot words, frame index, auto run length,
    // raw-button delay line, debounced level and the stable-run counter.
    logic [31:0] m_snap [4];
    logic [1:0]  m_frame = 2'd0;
    bit          m_init = 0;
    bit          m_raw1 = 0;
    bit          m_raw2 = 0;
    bit          m_level = 0;
    bit          m_pulse = 0;
    int          m_auto_edges = 0;
    int          m_run = 0;
    logic [63:0] exp_data = '0;
    logic [1:0]  exp_frame = 2'd0;
    logic [3:0]  exp_led = 4'b0001;

    task automatic model_load();
        m_snap[0] = i_a;
        m_snap[1] = i_b;
        m_snap[2] = i_c;
        m_snap[3] = {31'b0, i_zero};
    endtask

    task automatic model_reset();
        foreach (m_snap[i]) m_snap[i] = '0;
        m_frame = 2'd0;
        m_init = 0;
        m_raw1 = 0;
        m_raw2 = 0;
        m_level = 0;
        m_pulse = 0;
        m_auto_edges = 0;
        m_run = 0;
        exp_data = '0;
        exp_frame = 2'd0;
        exp_led = 4'b0001;
    endtask

    task automatic model_edge();
        bit tick;
        bit adv;
        bit synced;
        synced = m_raw2;
        tick = i_auto && (((m_auto_edges + 1) % TICK_DIV) == 0);
        adv = i_auto ? tick : m_pulse;
        exp_data = {32'h0, m_snap[m_frame]};
        exp_frame = m_frame;
        exp_led = 4'b0001 << m_frame;
        if (!m_init) begin
            model_load();
            m_init = 1;
        end else if (adv) begin
            if (m_frame == 2'd3) model_load();
            m_frame = m_frame + 2'd1;
        end
        m_auto_edges = i_auto ? m_auto_edges + 1 : 0;
        m_pulse = 0;
        if (synced != m_level) begin
            m_run++;
            if (m_run == DEBOUNCE_CYCLES) begin
                m_level = synced;
                m_run = 0;
                m_pulse = synced;
            end
        end else begin
            m_run = 0;
        end
        m_raw2 = m_raw1;
        m_raw1 = i_step;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) model_reset();
            else model_edge();
        end
    end

    task automatic cycle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        i_a = 32'hFFFFFFFD;
        i_b = 32'd3;
        i_c = 32'd0;
        i_zero = 1'b1;
        i_auto = 1'b0;
        i_step = 1'b0;
        cycle(3);
        checks++;
        if (o_data !== 64'h0 || o_frame !== 2'd0 || o_led !== 4'b0001 || o_disp_mode !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: got data=%h frame=%0d led=%b mode=%b expected 0/0/0001/0",
                     o_data, o_frame, o_led, o_disp_mode);
        end
        rstn = 1'b1;
        cycle(1);
        checks++;
        if (o_data !== 64'h0) begin
            errors++;
            $display("[TB] FAIL pre_load_data: got %h expected %h", o_data, 64'h0);
        end
        cycle(1);
        checks++;
        if (o_data !== 64'h00000000FFFFFFFD) begin
            errors++;
            $display("[TB] FAIL first_snapshot: got %h expected %h", o_data, 64'h00000000FFFFFFFD);
        end
        checks++;
        if (o_frame !== 2'd0 || o_led !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL first_frame: got frame=%0d led=%b expected 0/0001", o_frame, o_led);
        end
    endtask

    task automatic test_auto_sequence();
        logic [31:0] words [4];
        logic [31:0] want_word;
        logic [1:0]  want_frame;
        words = '{32'hFFFFFFFD, 32'd3, 32'd0, 32'd1};
        i_auto = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cycle(1);
            want_frame = 2'((k - 1) / TICK_DIV);
            want_word = (k > 4 * TICK_DIV) ? 32'd7 : words[want_frame];
            checks++;
            if (o_frame !== want_frame || o_led !== (4'b0001 << want_frame) || o_data !== {32'h0, want_word}) begin
                errors++;
                $display("[TB] FAIL auto_seq k=%0d: got frame=%0d led=%b data=%h expected frame=%0d data=%h",
                         k, o_frame, o_led, o_data, want_frame, want_word);
            end
            if (k == 6) i_a = 32'd7;
        end
        i_auto = 1'b0;
    endtask

    task automatic test_manual_step();
        logic [1:0] base;
        logic [1:0] want;
        cycle(3);
        base = exp_frame;
        i_step = 1'b1;
        cycle(5);
        i_step = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle(1);
            checks++;
            if (o_frame !== base) begin
                errors++;
                $display("[TB] FAIL glitch_no_advance k=%0d: got frame=%0d expected %0d", k, o_frame, base);
            end
        end
        i_step = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cycle(1);
            want = (k >= 2 + DEBOUNCE_CYCLES + 2) ? base + 2'd1 : base;
            checks++;
            if (o_frame !== want || o_led !== (4'b0001 << want)) begin
                errors++;
                $display("[TB] FAIL press_timing k=%0d: got frame=%0d led=%b expected frame=%0d",
                         k, o_frame, o_led, want);
            end
        end
        want = base + 2'd1;
        for (int k = 0; k < 33; k++) begin
            i_step = (k == 2 || k == 3 || k == 4 || k == 7) ? 1'b1 : 1'b0;
            cycle(1);
            checks++;
            if (o_frame !== want || {o_data, o_frame, o_led} !== {exp_data, exp_frame, exp_led}) begin
                errors++;
                $display("[TB] FAIL release_bounce k=%0d: got frame=%0d data=%h expected frame=%0d data=%h",
                         k, o_frame, o_data, want, exp_data);
            end
        end
    endtask

    task automatic test_auto_toggle();
        logic [1:0] base;
        logic [1:0] want;
        base = exp_frame;
        i_auto = 1'b1;
        cycle(2);
        i_auto = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle(1);
            checks++;
            if (o_frame !== base) begin
                errors++;
                $display("[TB] FAIL toggle_no_tick k=%0d: got frame=%0d expected %0d", k, o_frame, base);
            end
        end
        i_auto = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cycle(1);
            want = (k >= TICK_DIV + 1) ? base + 2'd1 : base;
            checks++;
            if (o_frame !== want) begin
                errors++;
                $display("[TB] FAIL retick_timing k=%0d: got frame=%0d expected %0d", k, o_frame, want);
            end
        end
        for (int k = 0; k < 40; k++) begin
            i_step = (k < 20) ? 1'b1 : 1'b0;
            cycle(1);
            checks++;
            if ({o_data, o_frame, o_led} !== {exp_data, exp_frame, exp_led}) begin
                errors++;
                $display("[TB] FAIL step_in_auto k=%0d: got data=%h frame=%0d expected data=%h frame=%0d",
                         k, o_data, o_frame, exp_data, exp_frame);
            end
        end
        i_auto = 1'b0;
        cycle(3);
    endtask

    task automatic test_reset_mid();
        logic [31:0] na;
        int guard;
        guard = 0;
        i_auto = 1'b1;
        while (m_frame != 2'd2 && guard < 40) begin
            cycle(1);
            guard++;
        end
        i_auto = 1'b0;
        checks++;
        if (m_frame != 2'd2) begin
            errors++;
            $display("[TB] FAIL reach_fc: got model frame=%0d expected 2 within 40 cycles", m_frame);
        end
        cycle(2);
        checks++;
        if (o_frame !== 2'd2) begin
            errors++;
            $display("[TB] FAIL at_fc: got frame=%0d expected 2", o_frame);
        end
        i_step = 1'b1;
        cycle(5);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (o_data !== 64'h0 || o_frame !== 2'd0 || o_led !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL async_reset: got data=%h frame=%0d led=%b expected 0/0/0001",
                     o_data, o_frame, o_led);
        end
        na = $urandom();
        i_a = na;
        i_b = $urandom();
        i_c = $urandom();
        i_zero = 1'b0;
        i_step = 1'b0;
        cycle(2);
        rstn = 1'b1;
        cycle(2);
        checks++;
        if (o_data !== {32'h0, na} || o_frame !== 2'd0 || o_led !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL fresh_snapshot: got data=%h frame=%0d expected data=%h frame=0",
                     o_data, o_frame, {32'h0, na});
        end
        for (int k = 0; k < 30; k++) begin
            i_step = (k < 15) ? 1'b1 : 1'b0;
            cycle(1);
            checks++;
            if ({o_data, o_frame, o_led} !== {exp_data, exp_frame, exp_led}) begin
                errors++;
                $display("[TB] FAIL post_reset k=%0d: got data=%h frame=%0d expected data=%h frame=%0d",
                         k, o_data, o_frame, exp_data, exp_frame);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int n = 0; n < 600; n++) begin
            cycle(1);
            checks++;
            if ({o_disp_mode, o_data, o_frame, o_led} !== {1'b0, exp_data, exp_frame, exp_led}) begin
                errors++;
                $display("[TB] FAIL random n=%0d: got mode=%b data=%h frame=%0d led=%b expected data=%h frame=%0d led=%b",
                         n, o_disp_mode, o_data, o_frame, o_led, exp_data, exp_frame, exp_led);
            end
            i_a = $urandom();
            i_b = $urandom();
            i_c = $urandom();
            i_zero = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) i_auto = ~i_auto;
            if (hold == 0) begin
                i_step = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 14));
            end else begin
                hold--;
            end
        end
    endtask

    initial begin
        test_reset();
        test_auto_sequence();
        test_manual_step();
        test_auto_toggle();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
